// File: rtl/shift_register_pkg.sv
// ---------------------------------------------------------------------------
// shift_register_pkg
//
// Shared definitions for the shift_register block:
//   - mode_t        : 2-bit operation select (hold / shift left / shift right /
//                     parallel load), encoded to match the s port directly.
//   - DEFAULT_WIDTH : default register width.
//   - MODE_W        : width of the mode select.
//
// Optional feature macro used by the block: SHIFT_REGISTER_SO_EN (adds the
// registered shifted-out bit output so).
// ---------------------------------------------------------------------------
package shift_register_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int MODE_W        = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHL  = 2'b01,
        MODE_SHR  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_t;

endpackage

// File: rtl/shift_register_next.sv
// ---------------------------------------------------------------------------
// shift_register_next
//
// Purely combinational next-state logic for shift_register.
//
// Ports:
//   i        in  WIDTH  parallel load data
//   s        in  2      mode select (see shift_register_pkg::mode_t)
//   r        in  1      serial fill bit for either shift direction
//   cur      in  WIDTH  current register contents
//   nxt      out WIDTH  register contents after the next rising edge
//   so_next  out 1      bit leaving the register on a shift, 0 otherwise
//                       (only when SHIFT_REGISTER_SO_EN is defined)
// ---------------------------------------------------------------------------
module shift_register_next
    import shift_register_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] i,
    input  logic [1:0]       s,
    input  logic             r,
    input  logic [WIDTH-1:0] cur,
`ifdef SHIFT_REGISTER_SO_EN
    output logic             so_next,
`endif
    output logic [WIDTH-1:0] nxt
);

    mode_t            mode;
    logic [WIDTH-1:0] shl_vec;
    logic [WIDTH-1:0] shr_vec;

    assign mode = mode_t'(s);

    // Build both shifted candidates bit by bit; the end bits take the serial
    // fill, everything else takes its neighbour. No wrap-around.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        if (gi == 0) begin : g_shl_lsb
            assign shl_vec[gi] = r;
        end else begin : g_shl_mid
            assign shl_vec[gi] = cur[gi-1];
        end

        if (gi == WIDTH - 1) begin : g_shr_msb
            assign shr_vec[gi] = r;
        end else begin : g_shr_mid
            assign shr_vec[gi] = cur[gi+1];
        end
    end

    // All four encodings are listed explicitly. The default arm only catches
    // X/Z on s in simulation and falls back to hold, so state is never
    // corrupted and no latch can be inferred (nxt is assigned on every path).
    always_comb begin
        nxt = cur;
        unique case (mode)
            MODE_HOLD: nxt = cur;
            MODE_SHL:  nxt = shl_vec;
            MODE_SHR:  nxt = shr_vec;
            MODE_LOAD: nxt = i;
            default:   nxt = cur;
        endcase
    end

`ifdef SHIFT_REGISTER_SO_EN
    // The discarded bit is exposed for one cycle; hold and load report 0.
    always_comb begin
        so_next = 1'b0;
        unique case (mode)
            MODE_SHL:  so_next = cur[WIDTH-1];
            MODE_SHR:  so_next = cur[0];
            MODE_HOLD: so_next = 1'b0;
            MODE_LOAD: so_next = 1'b0;
            default:   so_next = 1'b0;
        endcase
    end
`endif

endmodule

// File: rtl/shift_register.sv
// ---------------------------------------------------------------------------
// shift_register
//
// Parallel-load, bidirectional shift register with serial fill. One operation
// (hold / shift left / shift right / load) is applied per rising clock edge;
// the register drives o directly, so o has no combinational input path.
//
// Parameters:
//   WIDTH   register/data width in bits (must be >= 2)
//
// Ports:
//   clk     in  1      rising-edge clock
//   reset   in  1      asynchronous active-low reset, clears o (and so)
//   i       in  WIDTH  parallel load data
//   s       in  2      mode: 00 hold, 01 shift left, 10 shift right, 11 load
//   r       in  1      serial fill bit, enters the vacated end on a shift
//   o       out WIDTH  current register contents
//   so      out 1      registered shifted-out bit
//                      (present only when SHIFT_REGISTER_SO_EN is defined)
//
// Configuration macro: SHIFT_REGISTER_SO_EN
// ---------------------------------------------------------------------------
module shift_register
    import shift_register_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i,
    input  logic [1:0]       s,
    input  logic             r,
`ifdef SHIFT_REGISTER_SO_EN
    output logic             so,
`endif
    output logic [WIDTH-1:0] o
);

    logic [WIDTH-1:0] o_reg;
    logic [WIDTH-1:0] o_next;

`ifdef SHIFT_REGISTER_SO_EN
    logic so_reg;
    logic so_next;
`endif

    shift_register_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .i       (i),
        .s       (s),
        .r       (r),
        .cur     (o_reg),
`ifdef SHIFT_REGISTER_SO_EN
        .so_next (so_next),
`endif
        .nxt     (o_next)
    );

    // Reset is asynchronous on assertion; the first edge after release
    // simply applies whatever s selects at that time.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_reg <= '0;
        end else begin
            o_reg <= o_next;
        end
    end

    assign o = o_reg;

`ifdef SHIFT_REGISTER_SO_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            so_reg <= 1'b0;
        end else begin
            so_reg <= so_next;
        end
    end

    assign so = so_reg;
`endif

endmodule

// File: tb/tb_shift_register.sv
// ---------------------------------------------------------------------------
// tb_shift_register
//
// Directed plus random stimulus for shift_register (WIDTH = 8). Each driven
// operation pushes its expected result into a scoreboard queue; the result is
// popped and compared just after the rising edge that applies it.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_shift_register;
    import shift_register_pkg::*;

    localparam int W = 8;

    typedef struct packed {
        logic         so;
        logic [W-1:0] o;
    } exp_t;

    logic         clk;
    logic         reset;
    logic [W-1:0] i;
    logic [1:0]   s;
    logic         r;
    logic [W-1:0] o;
    logic         so_obs;

    int checks = 0;
    int errors = 0;

    exp_t         sb_q[$];
    logic [W-1:0] model_o;
    logic         model_so;

    shift_register #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .i     (i),
        .s     (s),
        .r     (r),
`ifdef SHIFT_REGISTER_SO_EN
        .so    (so_obs),
`endif
        .o     (o)
    );

`ifndef SHIFT_REGISTER_SO_EN
    assign so_obs = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_o(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s o observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic check_so(input string tag, input logic got, input logic exp);
`ifdef SHIFT_REGISTER_SO_EN
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s so observed=%b expected=%b", tag, got, exp);
        end
`endif
    endtask

    // Called at a falling edge: drives one operation, predicts the result,
    // checks it after the next rising edge and returns at the following
    // falling edge.
    task automatic step(input string tag, input logic [1:0] sv,
                        input logic [W-1:0] iv, input logic rv);
        exp_t e;
        exp_t got;
        s = sv;
        i = iv;
        r = rv;
        case (sv)
            2'b01:   begin e.o = {model_o[W-2:0], rv}; e.so = model_o[W-1]; end
            2'b10:   begin e.o = {rv, model_o[W-1:1]}; e.so = model_o[0];   end
            2'b11:   begin e.o = iv;                   e.so = 1'b0;         end
            default: begin e.o = model_o;              e.so = 1'b0;         end
        endcase
        sb_q.push_back(e);
        model_o  = e.o;
        model_so = e.so;
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        $display("step %-14s s=%b i=%h r=%b -> o=%b so=%b (exp o=%b so=%b)",
                 tag, sv, iv, rv, o, so_obs, got.o, got.so);
        check_o(tag, o, got.o);
        check_so(tag, so_obs, got.so);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        i = '0;
        s = 2'b00;
        r = 1'b0;
        model_o = '0;
        model_so = 1'b0;

        // Reset held low with a pending load: o clears without any edge.
        #1;
        reset = 1'b0;
        i = 8'hA5;
        s = 2'b11;
        #1;
        check_o("reset_async", o, 8'h00);
        check_so("reset_async", so_obs, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check_o("reset_held", o, 8'h00);
        check_so("reset_held", so_obs, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // First edge after release loads.
        step("first_load", 2'b11, 8'hA5, 1'b0);
        step("load_3c",    2'b11, 8'h3C, 1'b1);
        step("load_a5",    2'b11, 8'b10100101, 1'b1);
        step("hold_1",     2'b00, 8'h00, 1'b1);
        step("hold_2",     2'b00, 8'hFF, 1'b1);
        step("shl_r0",     2'b01, 8'h00, 1'b0);   // -> 01001010, so=1
        step("shr_r1",     2'b10, 8'h00, 1'b1);   // -> 10100101, so=0
        step("shr_r0",     2'b10, 8'h00, 1'b0);   // LSB 1 discarded
        step("shl_r1",     2'b01, 8'h00, 1'b1);
        step("load_ff",    2'b11, 8'hFF, 1'b0);

        // Async reset in the middle of continuous left shifting.
        s = 2'b01;
        r = 1'b1;
        #2;
        reset = 1'b0;
        model_o  = '0;
        model_so = 1'b0;
        #1;
        check_o("midshift_async", o, 8'h00);
        check_so("midshift_async", so_obs, 1'b0);
        @(posedge clk);
        #1;
        check_o("midshift_held", o, 8'h00);
        check_so("midshift_held", so_obs, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        step("shl_after_rst", 2'b01, 8'h00, 1'b1); // 00 shifted with r -> 01

        // Random operations against the reference model.
        for (int k = 0; k < 40; k++) begin
            step("random", 2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
